window_sum_pipe: RTL and testbench
==================================

# window_sum_pipe

Pipelined, parametrised window-sum engine for the detection path. Each accepted beat carries NUM_LANES signed lane values that are summed by a registered adder tree. Per-beat sums are then accumulated across the beats of a window, delimited by `in_last`. One result per window leaves through a valid/ready output; wrap or saturating overflow is selectable.

## Interface
- NUM_LANES, 8: lanes per beat; power of two, ≥2.
- LANE_W, 32: signed width of each lane.
- ACC_W, 48: signed width of tree nodes, accumulator and result; ≥ LANE_W + log2(NUM_LANES).
- CNT_W, 16: width of the beat counter.
- SATURATE, 0: 0 = two's-complement wrap in the accumulator; 1 = clamp to the ACC_W range.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  NUM_LANES*LANE_W  lane i at bits [LANE_W*i +: LANE_W], signed.
- in_valid  in  1  beat present.
- in_last  in  1  beat is the final beat of a window; qualified by in_valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- out_sum  out  ACC_W  signed window sum.
- out_beats  out  CNT_W  number of beats in the window; saturates at all-ones.
- out_ovf  out  1  accumulator overflowed during the window (sticky per window).
- out_valid  out  1  result present.
- out_ready  in  1  result consumed when out_valid && out_ready.

## Operation
- LEVELS = log2(NUM_LANES) registered tree stages. Stage 1 sign-extends the lanes to ACC_W and adds them in pairs; each later stage adds pairs of the previous stage. No rounding and no overflow is possible inside the tree.
- Each tree stage carries a valid bit and a last bit alongside its data.
- Global stall = out_valid && !out_ready. When stalled, every pipeline register, the accumulator and the counter hold; in_ready = !stall. There are no other back-pressure sources.
- Accumulator stage, fed from tree stage LEVELS when valid and not stalled:
  - acc_next = (first beat of window ? 0 : acc) + tree_sum; cnt_next = (first ? 0 : cnt) + 1, saturating.
  - SATURATE=0: wrap. SATURATE=1: on signed overflow, clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1). In both modes set ovf.
  - If the beat is last, load out_sum/out_beats/out_ovf from the next values, set out_valid, and mark the next beat as first of a new window.
- Non-last beats never raise out_valid.
- out_valid clears on handshake unless a new last beat arrives in the same cycle, in which case the new result is loaded and out_valid stays 1.
- Reset values: out_valid=0, out_sum=0, out_beats=0, out_ovf=0, all stage valids 0, accumulator 0, first=1. in_ready=1 in the cycle after reset. Reset asserted mid-window discards all partial data.
- A single-beat window (in_last on its first beat) gives out_sum = tree sum and out_beats = 1.

## Timing
- Beat accepted at edge t: tree stage k loads at t+k-1; accumulator/output loads at t+LEVELS. out_valid is visible from t+LEVELS until the handshake. Latency is LEVELS+1 edges (4 at default).
- Throughput is one beat per cycle with no stall. Back-to-back windows need no bubble.
- in_ready is combinational from out_valid/out_ready only. in_data is not combinationally used.
- Outputs are stable while out_valid && !out_ready.

## Structure
- Package `window_sum_pkg`: clog2 constant function, `sat_add` function (ACC_W-generic signed add with overflow flag), and the sign-extension helper.
- Sub-module `adder_tree_stage`: one registered level. Parameters are input count and ACC_W. It carries valid/last and has an enable port driven by !stall. It is instantiated LEVELS times via generate.
- The top level holds the accumulator, counter, output register and stall logic.

## Test plan
- Default parameters, one beat with lanes 1..8, in_last=1, out_ready=1: out_sum=36, out_beats=1, out_ovf=0, out_valid exactly at acceptance+4.
- Window of 3 beats, all lanes = -5, continuous, out_ready=1: out_sum=-120, out_beats=3, one out_valid pulse; the next window starts on the following cycle without a bubble.
- Stall: hold out_ready=0 for 5 cycles with valid result present: in_ready=0, out_sum stable, the beat offered during the stall is accepted after release, and no data is lost or duplicated.
- ACC_W=34, SATURATE=1, 2 beats of all lanes = 0x7FFFFFFF: out_sum=2^33-1, out_ovf=1. Same with SATURATE=0: wrapped value, out_ovf=1.
- rst asserted after 2 beats of a 4-beat window, then a fresh 1-beat window of lanes=2: out_sum=16, out_beats=1, and nothing from the aborted window appears.
- Random in_valid/out_ready over 10k beats against a reference model: sums, counts and order match.

Source files
------------

// File: rtl/window_sum_pkg.sv
// window_sum_pkg: shared helpers for the window-sum engine.
//   clog2    - constant ceil(log2) for sizing the adder tree
//   sext     - sign-extend the low w bits of a MAX_W vector
//   sat_add  - signed add of two w-bit values (carried in MAX_W containers)
//              returning the wrapped or clamped result plus an overflow flag
// Callers keep their widths strictly below MAX_W so the MAX_W add is exact.
package window_sum_pkg;

  localparam int MAX_W = 128;

  typedef struct packed {
    logic                    ovf;
    logic signed [MAX_W-1:0] sum;
  } add_res_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic logic signed [MAX_W-1:0] sext(input logic [MAX_W-1:0] v, input int w);
    logic signed [MAX_W-1:0] t;
    t = v << (MAX_W - w);
    return t >>> (MAX_W - w);
  endfunction

  // a and b must already be sign-extended w-bit values.
  function automatic add_res_t sat_add(input logic signed [MAX_W-1:0] a,
                                       input logic signed [MAX_W-1:0] b,
                                       input int w, input logic sat);
    logic signed [MAX_W-1:0] s, hi, lo;
    add_res_t r;
    hi    = (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    lo    = ~hi;                         // -2^(w-1)
    s     = a + b;
    r.ovf = (s > hi) || (s < lo);
    if (!r.ovf)   r.sum = s;
    else if (sat) r.sum = (s > hi) ? hi : lo;
    else          r.sum = sext(s, w);
    return r;
  endfunction

endpackage

// File: rtl/window_sum_pipe_tree.sv
// adder_tree_stage: one registered level of the lane adder tree.
//   in_data/in_valid/in_last  - N_IN ACC_W-wide nodes from the level below
//   out_data/out_valid/out_last - N_IN/2 pairwise sums, registered
//   en  - pipeline advance (low while the output is stalled)
// out_last is already qualified by valid so downstream can use it directly.
module adder_tree_stage #(
  parameter int N_IN  = 2,
  parameter int ACC_W = 48
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [N_IN-1:0][ACC_W-1:0]     in_data,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic [N_IN/2-1:0][ACC_W-1:0]   out_data,
  output logic                           out_valid,
  output logic                           out_last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (en) begin
      for (int j = 0; j < N_IN/2; j++)
        out_data[j] <= in_data[2*j] + in_data[2*j+1];
      out_valid <= in_valid;
      out_last  <= in_valid && in_last;
    end
  end

endmodule

// File: rtl/window_sum_pipe.sv
// window_sum_pipe: per-beat lane sum through a registered adder tree, then
// accumulated across a window closed by in_last. One result per window.
//   in_data/in_valid/in_last/in_ready   - beat input, NUM_LANES signed lanes
//   out_sum/out_beats/out_ovf/out_valid/out_ready - one result per window
// The only back-pressure is a held result (out_valid && !out_ready), which
// freezes the whole pipeline, so in_ready is a pure function of the outputs.
module window_sum_pipe
  import window_sum_pkg::*;
#(
  parameter int NUM_LANES = 8,
  parameter int LANE_W    = 32,
  parameter int ACC_W     = 48,
  parameter int CNT_W     = 16,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_LANES*LANE_W-1:0] in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [ACC_W-1:0]            out_sum,
  output logic [CNT_W-1:0]            out_beats,
  output logic                        out_ovf,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int LEVELS = clog2(NUM_LANES);
  localparam int NODES  = 2*NUM_LANES - 1;

  logic stall, en;
  assign stall    = out_valid && !out_ready;
  assign en       = !stall;
  assign in_ready = en;

  // Node store: level k inputs live at offset 2N - (2N >> k), so level 0 is
  // the extended lanes and the final single sum sits at NODES-1.
  logic [NODES-1:0][ACC_W-1:0] nodes;
  logic [LEVELS:0]             vld_pipe, lst_pipe;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_ext
    assign nodes[i] = ACC_W'(sext(MAX_W'(in_data[LANE_W*i +: LANE_W]), LANE_W));
  end
  assign vld_pipe[0] = in_valid;
  assign lst_pipe[0] = in_last;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int N_IN  = NUM_LANES >> k;
    localparam int OFF_I = 2*NUM_LANES - ((2*NUM_LANES) >> k);
    localparam int OFF_O = OFF_I + N_IN;
    adder_tree_stage #(.N_IN(N_IN), .ACC_W(ACC_W)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_data   (nodes[OFF_I +: N_IN]),
      .in_valid  (vld_pipe[k]),
      .in_last   (lst_pipe[k]),
      .out_data  (nodes[OFF_O +: N_IN/2]),
      .out_valid (vld_pipe[k+1]),
      .out_last  (lst_pipe[k+1])
    );
  end

  logic             tv, tl;
  logic [ACC_W-1:0] tsum;
  assign tv   = vld_pipe[LEVELS];
  assign tl   = lst_pipe[LEVELS];
  assign tsum = nodes[NODES-1];

  // Accumulator; "first" makes the next beat start from zero so windows can
  // run back to back without a clearing bubble.
  logic [ACC_W-1:0] acc, acc_base, acc_next;
  logic [CNT_W-1:0] cnt, cnt_base, cnt_next;
  logic             ovf, ovf_next, first;
  add_res_t         ar;
  logic             unused_hi;

  always_comb begin
    acc_base = first ? '0 : acc;
    cnt_base = first ? '0 : cnt;
    ar       = sat_add(sext(MAX_W'(acc_base), ACC_W), sext(MAX_W'(tsum), ACC_W),
                       ACC_W, SATURATE);
    acc_next = ar.sum[ACC_W-1:0];
    ovf_next = (!first && ovf) || ar.ovf;
    cnt_next = (&cnt_base) ? cnt_base : cnt_base + 1'b1;
  end
  assign unused_hi = ^ar.sum[MAX_W-1:ACC_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      first     <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_beats <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      // en implies any held result is being consumed this edge.
      out_valid <= tv && tl;
      if (tv) begin
        acc   <= acc_next;
        cnt   <= cnt_next;
        ovf   <= ovf_next;
        first <= tl;
        if (tl) begin
          out_sum   <= acc_next;
          out_beats <= cnt_next;
          out_ovf   <= ovf_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_sum_pipe.sv
module tb_window_sum_pipe;
  localparam int NL = 8, LW = 32, AW = 48, CW = 16;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [NL*LW-1:0] in_data = '0;
  logic in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [AW-1:0] out_sum;
  logic [CW-1:0] out_beats;
  logic out_ovf, out_valid, out_ready = 1'b1;

  window_sum_pipe #(.NUM_LANES(NL), .LANE_W(LW), .ACC_W(AW), .CNT_W(CW), .SATURATE(1'b0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_sum(out_sum), .out_beats(out_beats), .out_ovf(out_ovf),
    .out_valid(out_valid), .out_ready(out_ready));

  // 4-lane, 34-bit accumulators for overflow behaviour
  logic [4*LW-1:0] s_data = '0;
  logic s_valid = 1'b0, s_last = 1'b0;
  logic rdy_a, rdy_b, v_a, v_b, o_a, o_b;
  logic [33:0] sum_a, sum_b;
  logic [CW-1:0] b_a, b_b;

  window_sum_pipe #(.NUM_LANES(4), .LANE_W(LW), .ACC_W(34), .CNT_W(CW), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .in_data(s_data), .in_valid(s_valid), .in_last(s_last),
    .in_ready(rdy_a), .out_sum(sum_a), .out_beats(b_a), .out_ovf(o_a),
    .out_valid(v_a), .out_ready(1'b1));

  window_sum_pipe #(.NUM_LANES(4), .LANE_W(LW), .ACC_W(34), .CNT_W(CW), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .in_data(s_data), .in_valid(s_valid), .in_last(s_last),
    .in_ready(rdy_b), .out_sum(sum_b), .out_beats(b_b), .out_ovf(o_b),
    .out_valid(v_b), .out_ready(1'b1));

  typedef struct { longint sum; int beats; bit ovf; } res_t;
  res_t exp_q[$], got_q[$];

  int tests = 0, fails = 0, accepted = 0;
  longint m_acc = 0;
  int m_cnt = 0;
  bit m_ovf = 1'b0, m_first = 1'b1;
  logic seen_valid, seen_ready;
  logic [AW-1:0] seen_sum;
  localparam longint AMAX = (64'sd1 <<< (AW-1)) - 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NL*LW-1:0] fill(input int base, input int step);
    logic [NL*LW-1:0] d;
    for (int i = 0; i < NL; i++) d[i*LW +: LW] = LW'(base + step*i);
    return d;
  endfunction

  function automatic longint beat_sum(input logic [NL*LW-1:0] d);
    longint s;
    logic signed [LW-1:0] l;
    s = 0;
    for (int i = 0; i < NL; i++) begin
      l = d[i*LW +: LW];
      s += longint'(l);
    end
    return s;
  endfunction

  // One clock: observe handshakes at the falling edge, check results against
  // the window model, then let the rising edge happen.
  task automatic cycle();
    res_t e, g;
    longint t;
    int cb;
    bit ob;
    @(negedge clk);
    seen_valid = out_valid;
    seen_ready = in_ready;
    seen_sum   = out_sum;
    if (rst) begin
      exp_q.delete();
      m_first = 1'b1; m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        g.sum = longint'($signed(out_sum)); g.beats = int'(out_beats); g.ovf = out_ovf;
        got_q.push_back(g);
        chk("result_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sum",   64'(out_sum),   64'(e.sum[AW-1:0]));
          chk("beats", 64'(out_beats), 64'(e.beats));
          chk("ovf",   64'(out_ovf),   64'(e.ovf));
        end
      end
      if (in_valid && in_ready) begin
        accepted++;
        t  = (m_first ? 0 : m_acc) + beat_sum(in_data);
        cb = m_first ? 0 : m_cnt;
        ob = m_first ? 1'b0 : m_ovf;
        if (t > AMAX || t < -AMAX - 1) begin
          ob = 1'b1;
          t  = (t <<< (64-AW)) >>> (64-AW);
        end
        m_acc = t; m_cnt = (cb == (1 << CW) - 1) ? cb : cb + 1; m_ovf = ob;
        m_first = in_last;
        if (in_last) exp_q.push_back('{t, m_cnt, ob});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) cycle();
    cycle(); cycle();
    chk(tag, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int start;
    logic [AW-1:0] held;

    // reset state
    rst = 1'b1; cycle(); cycle(); rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_sum",   64'(out_sum),   64'(0));
    chk("rst_out_beats", 64'(out_beats), 64'(0));
    chk("rst_out_ovf",   64'(out_ovf),   64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));

    // single beat 1..8, latency
    got_q.delete();
    in_data = fill(1, 1); in_valid = 1'b1; in_last = 1'b1; cycle();
    in_valid = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk($sformatf("lat_valid_%0d", i), 64'(seen_valid), 64'(i == 3));
    end
    chk("t1_count", 64'(got_q.size()), 64'(1));
    if (got_q.size() == 1) begin
      chk("t1_sum",   64'(got_q[0].sum),   64'(36));
      chk("t1_beats", 64'(got_q[0].beats), 64'(1));
      chk("t1_ovf",   64'(got_q[0].ovf),   64'(0));
    end

    // 3-beat window of -5 then a 1-beat window back to back
    got_q.delete();
    in_data = fill(-5, 0); in_valid = 1'b1; in_last = 1'b0;
    cycle(); cycle();
    in_last = 1'b1; cycle();
    in_data = fill(7, 0); cycle();
    chk("b2b_ready", 64'(seen_ready), 64'(1));
    in_valid = 1'b0; in_last = 1'b0;
    drain("t2_drain");
    chk("t2_count", 64'(got_q.size()), 64'(2));
    if (got_q.size() == 2) begin
      chk("t2_sum",    64'(got_q[0].sum),   64'(-120));
      chk("t2_beats",  64'(got_q[0].beats), 64'(3));
      chk("t2b_sum",   64'(got_q[1].sum),   64'(56));
      chk("t2b_beats", 64'(got_q[1].beats), 64'(1));
    end

    // stall with a held result
    got_q.delete();
    out_ready = 1'b0;
    in_data = fill(3, 1); in_valid = 1'b1; in_last = 1'b1; cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) cycle();
    chk("stall_valid", 64'(out_valid), 64'(1));
    chk("stall_a_sum", 64'(out_sum), 64'(52));
    held = out_sum;
    in_data = fill(-2, 3); in_valid = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_in_ready", 64'(seen_ready), 64'(0));
      chk("stall_sum_hold", 64'(seen_sum), 64'(held));
    end
    out_ready = 1'b1; cycle();
    in_valid = 1'b0; in_last = 1'b0;
    drain("t3_drain");
    chk("t3_count", 64'(got_q.size()), 64'(2));
    if (got_q.size() == 2) begin
      chk("t3_a_sum", 64'(got_q[0].sum), 64'(52));
      chk("t3_b_sum", 64'(got_q[1].sum), 64'(68));
    end

    // 34-bit overflow, saturating and wrapping
    s_data = {4{32'h7FFF_FFFF}}; s_valid = 1'b1; s_last = 1'b0; cycle();
    s_last = 1'b1; cycle();
    s_valid = 1'b0; s_last = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("sat_sum",   64'(sum_a), 64'(34'h1_FFFF_FFFF));
    chk("sat_ovf",   64'(o_a),   64'(1));
    chk("sat_beats", 64'(b_a),   64'(2));
    chk("wrap_sum",  64'(sum_b), 64'(34'h3_FFFF_FFF8));
    chk("wrap_ovf",  64'(o_b),   64'(1));

    // reset mid-window
    got_q.delete();
    in_data = fill(9, 1); in_valid = 1'b1; in_last = 1'b0; cycle(); cycle();
    in_valid = 1'b0; rst = 1'b1; cycle(); rst = 1'b0;
    chk("rst_mid_valid", 64'(out_valid), 64'(0));
    in_data = fill(2, 0); in_valid = 1'b1; in_last = 1'b1; cycle();
    in_valid = 1'b0; in_last = 1'b0;
    drain("t5_drain");
    chk("t5_count", 64'(got_q.size()), 64'(1));
    if (got_q.size() == 1) begin
      chk("t5_sum",   64'(got_q[0].sum),   64'(16));
      chk("t5_beats", 64'(got_q[0].beats), 64'(1));
    end

    // random traffic against the model
    got_q.delete();
    start = accepted;
    for (int c = 0; c < 40000 && accepted - start < 10000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NL; i++) in_data[i*LW +: LW] = $urandom();
      cycle();
    end
    chk("rand_beats", 64'(accepted - start >= 10000), 64'(1));
    in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b1; cycle();
    in_valid = 1'b0; in_last = 1'b0;
    drain("rand_drain");
    chk("rand_results", 64'(got_q.size() > 100), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
